pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage ARM pipeline (F/D/E/M/W).
//  Tracks each in-flight instruction's destination, write-enable, load and
//  PC-write flags through E/M/W, and from them generates:
//   - forwarding selects for the three decode read ports (RA1, RA2, Rs);
//   - load-use stalls and bubbles;
//   - stall/flush for PC writes and taken branches;
//   - stalls for a multi-cycle multiply.
//  Drives the decode register's stall input and the E-stage flush.
// PARAMETERS
//  MUL_LAT  3  Cycles a multiply occupies E (>=2); F/D held for MUL_LAT-1 cycles
// PORTS
//  clk          in   1  single clock; all state on rising edge
//  reset        in   1  asynchronous, active-low; clears all state
//  RA1D         in   4  decode read port 1 register (after RegSrc mux)
//  RA2D         in   4  decode read port 2 register
//  RA3D         in   4  decode shift-register read (Instr[11:8])
//  RdD          in   4  decode destination register
//  RegWriteD    in   1  decode instruction writes register file
//  MemtoRegD    in   1  decode instruction is a load
//  PCSrcD       in   1  decode instruction writes PC (R15 / branch)
//  MulStartD    in   1  decode instruction is a multi-cycle multiply
//  BranchTakenE in   1  branch in E resolved taken
//  StallF       out  1  hold PC register
//  StallD       out  1  hold decode register (feeds decode stall)
//  FlushD       out  1  clear decode register to bubble
//  FlushE       out  1  clear execute register to bubble
//  ForwardAE    out  2  src A select: 00 regfile, 01 ResultW, 10 ALUResultM
//  ForwardBE    out  2  src B select, same encoding
//  ForwardSE    out  2  Rs (shift amount) select, same encoding
//  MulDoneE     out  1  one-cycle pulse: multiply completes this cycle
// BEHAVIOUR
//  - Reset: tracking regs E/M/W cleared (RegWrite=0, PCSrc=0, MemtoReg=0),
//    FSM=RUN, counter=0. While reset low, all outputs 0.
//  - Tracking: E captures D fields + RA1/2/3 when !StallD.
//    E is cleared when FlushE or StallD. M<=E and W<=M every cycle.
//  - Forwarding, per port X in E:
//    - 10 if RAXE==RdM & RegWriteM;
//    - else 01 if RAXE==RdW & RegWriteW;
//    - else 00.
//    M has priority over W. RAXE==15 always selects 00 (PC comes from PCPlus8).
//  - ldrStall = MemtoRegE & RegWriteE & RdE in {RA1D,RA2D,RA3D} & !BranchTakenE.
//  - PCWrPend = PCSrcD|PCSrcE|PCSrcM.
//  - Outputs in RUN:
//    - StallF = ldrStall | PCWrPend;
//    - StallD = ldrStall;
//    - FlushD = PCWrPend | PCSrcW | BranchTakenE;
//    - FlushE = ldrStall | BranchTakenE.
//  - FSM: RUN -> MUL when MulStartD & !StallD & !FlushD.
//    - On that entry edge, cnt <= MUL_LAT-2.
//    - In MUL: StallF=StallD=1 and FlushD=FlushE=0. The multiply stays in E
//      and M/W drain normally; M captures a bubble while in MUL.
//    - cnt decrements each cycle. At cnt==0, MulDoneE=1 and the next state
//      is RUN; the multiply then advances to M.
//  - Simultaneous events:
//    - BranchTakenE masks ldrStall and MulStartD (the D instruction is squashed).
//    - ldrStall with MulStartD: the multiply waits in D and is accepted when
//      the stall clears.
//    - A PC write behind a multiply waits in D (StallD) until the FSM returns
//      to RUN.
//  - Reset mid-multiply: FSM to RUN, counter 0, no MulDoneE.
//  - Forwarding and stall outputs are combinational from tracked state plus
//    D inputs. Zero cycles of extra latency; every stall lasts exactly one
//    cycle per load-use hazard.
// STRUCTURE
//  - pipe_ctrl_pkg:
//    - fwd_sel_t {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10};
//    - ctrl_state_t {RUN, MUL};
//    - REG_PC=4'd15;
//    - stage_info_t struct {rd, regwrite, memtoreg, pcsrc}.
//  - Sub-module ctrl_stage_reg: one stage_info_t register with async active-low
//    clear, enable and sync flush. Instantiated for E, M, W.
//  - Forward compare logic is a function in the package, used 3x.
// TESTING
//  1. Reset low mid-run -> all outputs 0 immediately; after release with
//     no hazards, all outputs stay 0.
//  2. ADD R1 then ADD R2,R1,R3 -> ForwardAE=10 for one cycle.
//     With one unrelated op between them -> ForwardAE=01.
//  3. LDR R4,[R0] then SUB R5,R4,#1 -> StallF=StallD=FlushE=1 for exactly
//     one cycle; then ForwardAE=01.
//  4. MOV PC,R2 -> StallF=1 for 3 cycles and FlushD=1 for 4 cycles.
//     A taken branch B in E -> FlushD=FlushE=1 for 1 cycle.
//  5. MUL with MUL_LAT=3 -> StallF=StallD=1 for 2 cycles and MulDoneE on the
//     2nd; a dependent ADD next gets ForwardAE=10.
//  6. LDR R4 in E while a taken branch is in E-adjacent D with R4 use ->
//     FlushD/FlushE only, no stall. Reset asserted during MUL ->
//     no MulDoneE, FSM RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and forwarding compare for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } ctrl_state_t;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef struct packed {
        logic [3:0] rd;
        logic       regwrite;
        logic       memtoreg;
        logic       pcsrc;
    } stage_info_t;

    // M wins over W; R15 reads always come from PCPlus8 via the register-file path.
    function automatic fwd_sel_t fwd_select(input logic [3:0] ra,
                                            input stage_info_t m,
                                            input stage_info_t w);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (ra == REG_PC)
            sel = FWD_RF;
        else if (m.regwrite && (ra == m.rd))
            sel = FWD_M;
        else if (w.regwrite && (ra == w.rd))
            sel = FWD_W;
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// rtl/ctrl_stage_reg.sv - one pipeline stage of tracked destination/control flags
module ctrl_stage_reg
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        flush,
    input  stage_info_t d,
    output stage_info_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (flush)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding, load-use, PC-write and multiply sequencing for the 5-stage pipe
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA3D,
    input  logic [3:0] RdD,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic       PCSrcD,
    input  logic       MulStartD,
    input  logic       BranchTakenE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic [1:0] ForwardSE,
    output logic       MulDoneE
);

    localparam int CNT_W = $clog2(MUL_LAT);

    stage_info_t          info_d, info_e, info_m, info_w;
    logic [3:0]           ra1_e, ra2_e, ra3_e;
    ctrl_state_t          state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 ldr_stall, pc_wr_pend;
    logic                 stall_f, stall_d, flush_d, flush_e, mul_done;
    logic                 in_run, e_flush;
    fwd_sel_t             fwd_a, fwd_b, fwd_s;
    logic                 unused_bits;

    assign info_d = '{rd: RdD, regwrite: RegWriteD, memtoreg: MemtoRegD, pcsrc: PCSrcD};
    assign in_run = (state == RUN);
    // While a multiply occupies E, the E register simply holds it.
    assign e_flush = flush_e | (stall_d & in_run);

    ctrl_stage_reg u_stage_e (
        .clk   (clk),
        .rst_n (reset),
        .en    (!stall_d),
        .flush (e_flush),
        .d     (info_d),
        .q     (info_e)
    );

    ctrl_stage_reg u_stage_m (
        .clk   (clk),
        .rst_n (reset),
        .en    (1'b1),
        .flush (!in_run),
        .d     (info_e),
        .q     (info_m)
    );

    ctrl_stage_reg u_stage_w (
        .clk   (clk),
        .rst_n (reset),
        .en    (1'b1),
        .flush (1'b0),
        .d     (info_m),
        .q     (info_w)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1_e <= '0;
            ra2_e <= '0;
            ra3_e <= '0;
        end else if (e_flush) begin
            ra1_e <= '0;
            ra2_e <= '0;
            ra3_e <= '0;
        end else if (!stall_d) begin
            ra1_e <= RA1D;
            ra2_e <= RA2D;
            ra3_e <= RA3D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        ldr_stall  = info_e.memtoreg & info_e.regwrite & !BranchTakenE &
                     ((info_e.rd == RA1D) | (info_e.rd == RA2D) | (info_e.rd == RA3D));
        pc_wr_pend = PCSrcD | info_e.pcsrc | info_m.pcsrc;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        mul_done  = 1'b0;
        case (state)
            RUN: begin
                stall_f = ldr_stall | pc_wr_pend;
                stall_d = ldr_stall;
                flush_d = pc_wr_pend | info_w.pcsrc | BranchTakenE;
                flush_e = ldr_stall | BranchTakenE;
                // A squashed or stalled multiply is not accepted yet.
                if (MulStartD && !stall_d && !flush_d) begin
                    state_nxt = MUL;
                    cnt_nxt   = CNT_W'(MUL_LAT - 2);
                end
            end
            MUL: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                if (cnt == '0) begin
                    mul_done  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        fwd_a = fwd_select(ra1_e, info_m, info_w);
        fwd_b = fwd_select(ra2_e, info_m, info_w);
        fwd_s = fwd_select(ra3_e, info_m, info_w);
    end

    assign unused_bits = ^{info_m.memtoreg, info_w.memtoreg};

    assign StallF    = reset & stall_f;
    assign StallD    = reset & stall_d;
    assign FlushD    = reset & flush_d;
    assign FlushE    = reset & flush_e;
    assign MulDoneE  = reset & mul_done;
    assign ForwardAE = {2{reset}} & fwd_a;
    assign ForwardBE = {2{reset}} & fwd_b;
    assign ForwardSE = {2{reset}} & fwd_s;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA3D, RdD;
    logic       RegWriteD, MemtoRegD, PCSrcD, MulStartD, BranchTakenE;
    logic       StallF, StallD, FlushD, FlushE, MulDoneE;
    logic [1:0] ForwardAE, ForwardBE, ForwardSE;

    logic          rst_v;
    int            n_checks = 0;
    int            n_fail   = 0;
    string         tag_q[$];
    logic [10:0]   exp_q[$];

    localparam logic [10:0] E0 = 11'b0;

    pipe_hazard_ctrl #(.MUL_LAT(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA3D         (RA3D),
        .RdD          (RdD),
        .RegWriteD    (RegWriteD),
        .MemtoRegD    (MemtoRegD),
        .PCSrcD       (PCSrcD),
        .MulStartD    (MulStartD),
        .BranchTakenE (BranchTakenE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .ForwardSE    (ForwardSE),
        .MulDoneE     (MulDoneE)
    );

    always #5 clk = ~clk;

    // Packed as {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardSE, MulDoneE}
    function automatic logic [10:0] mk(input logic sf, input logic sd, input logic fd, input logic fe,
                                       input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fs,
                                       input logic md);
        return {sf, sd, fd, fe, fa, fb, fs, md};
    endfunction

    task automatic check_val(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (sf sd fd fe fa fb fs md)", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] ra1, input logic [3:0] ra2,
                        input logic [3:0] ra3, input logic [3:0] rd, input logic rw,
                        input logic mtr, input logic pcs, input logic mul, input logic bt,
                        input logic [10:0] exp);
        @(posedge clk);
        #1;
        reset        = rst_v;
        RA1D         = ra1;
        RA2D         = ra2;
        RA3D         = ra3;
        RdD          = rd;
        RegWriteD    = rw;
        MemtoRegD    = mtr;
        PCSrcD       = pcs;
        MulStartD    = mul;
        BranchTakenE = bt;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic nop(input string tag, input logic [10:0] exp);
        step(tag, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0)
            check_val(tag_q.pop_front(),
                      {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardSE, MulDoneE},
                      exp_q.pop_front());
    end

    initial begin
        reset = 1'b0; rst_v = 1'b0;
        RA1D = '0; RA2D = '0; RA3D = '0; RdD = '0;
        RegWriteD = 0; MemtoRegD = 0; PCSrcD = 0; MulStartD = 0; BranchTakenE = 0;

        step("rst_pcsrc", 4'd1, 4'd0, 4'd0, 4'd15, 1, 0, 1, 1, 1, E0);
        step("rst_hold",  4'd4, 4'd4, 4'd4, 4'd4,  1, 1, 1, 1, 1, E0);
        rst_v = 1'b1;
        nop("idle_0", E0);
        nop("idle_1", E0);
        nop("idle_2", E0);

        step("fwd_m_prod", 4'd2, 4'd3, 4'd0, 4'd1, 1, 0, 0, 0, 0, E0);
        step("fwd_m_cons", 4'd1, 4'd3, 4'd0, 4'd2, 1, 0, 0, 0, 0, E0);
        nop("fwd_m_sel", mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0));
        nop("fwd_m_once", E0);
        nop("drain", E0);
        nop("drain", E0);

        step("fwd_w_prod", 4'd2, 4'd3, 4'd0, 4'd1, 1, 0, 0, 0, 0, E0);
        step("fwd_w_gap",  4'd7, 4'd8, 4'd0, 4'd6, 1, 0, 0, 0, 0, E0);
        step("fwd_w_cons", 4'd1, 4'd3, 4'd1, 4'd2, 1, 0, 0, 0, 0, E0);
        nop("fwd_w_sel", mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0));
        nop("fwd_w_once", E0);
        nop("drain", E0);
        nop("drain", E0);

        step("prio_w9a",    4'd0, 4'd0, 4'd0, 4'd9, 1, 0, 0, 0, 0, E0);
        step("prio_w9b",    4'd0, 4'd0, 4'd0, 4'd9, 1, 0, 0, 0, 0, E0);
        step("prio_cons",   4'd9, 4'd15, 4'd0, 4'd10, 1, 0, 0, 0, 0, E0);
        step("prio_m_over_w", 4'd0, 4'd0, 4'd0, 4'd15, 1, 0, 0, 0, 0,
             mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0));
        step("pc_reg_cons", 4'd15, 4'd15, 4'd15, 4'd0, 0, 0, 0, 0, 0, E0);
        nop("pc_reg_sel", E0);
        nop("drain", E0);
        nop("drain", E0);

        step("ldr_issue",     4'd0, 4'd0, 4'd0, 4'd4, 1, 1, 0, 0, 0, E0);
        step("ldr_use_stall", 4'd4, 4'd0, 4'd0, 4'd5, 1, 0, 0, 0, 0, mk(1, 1, 0, 1, 2'b00, 2'b00, 2'b00, 0));
        step("ldr_use_held",  4'd4, 4'd0, 4'd0, 4'd5, 1, 0, 0, 0, 0, E0);
        nop("ldr_use_fwd", mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
        nop("ldr_after", E0);
        step("ldr3_issue", 4'd0, 4'd0, 4'd0, 4'd7, 1, 1, 0, 0, 0, E0);
        step("ldr3_stall", 4'd0, 4'd0, 4'd7, 4'd8, 1, 0, 0, 0, 0, mk(1, 1, 0, 1, 2'b00, 2'b00, 2'b00, 0));
        step("ldr3_held",  4'd0, 4'd0, 4'd7, 4'd8, 1, 0, 0, 0, 0, E0);
        nop("ldr3_fwd", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0));
        nop("drain", E0);
        nop("drain", E0);

        step("pcw_d", 4'd0, 4'd2, 4'd0, 4'd15, 1, 0, 1, 0, 0, mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
        nop("pcw_e", mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
        nop("pcw_m", mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
        nop("pcw_w", mk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
        nop("pcw_done", E0);
        step("br_taken", 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, mk(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0));
        nop("br_after", E0);

        step("mul_issue",   4'd1, 4'd2, 4'd0, 4'd3, 1, 0, 0, 1, 0, E0);
        step("mul_stall_1", 4'd3, 4'd0, 4'd0, 4'd8, 1, 0, 0, 0, 0, mk(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        step("mul_done",    4'd3, 4'd0, 4'd0, 4'd8, 1, 0, 0, 0, 0, mk(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 1));
        step("mul_release", 4'd3, 4'd0, 4'd0, 4'd8, 1, 0, 0, 0, 0, E0);
        nop("mul_fwd", mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0));
        nop("mul_after", E0);

        step("ldr_br_issue", 4'd0, 4'd0, 4'd0, 4'd4, 1, 1, 0, 0, 0, E0);
        step("ldr_br_flush", 4'd4, 4'd0, 4'd0, 4'd5, 1, 0, 0, 0, 1, mk(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0));
        nop("ldr_br_after", E0);
        step("mul_br_squash", 4'd0, 4'd0, 4'd0, 4'd3, 1, 0, 0, 1, 1, mk(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0));
        nop("mul_br_after", E0);

        step("ldr_mul_issue",  4'd0, 4'd0, 4'd0, 4'd4, 1, 1, 0, 0, 0, E0);
        step("ldr_mul_stall",  4'd4, 4'd0, 4'd0, 4'd3, 1, 0, 0, 1, 0, mk(1, 1, 0, 1, 2'b00, 2'b00, 2'b00, 0));
        step("ldr_mul_accept", 4'd4, 4'd0, 4'd0, 4'd3, 1, 0, 0, 1, 0, E0);
        nop("ldr_mul_wait", mk(1, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0));
        nop("ldr_mul_done", mk(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 1));
        nop("ldr_mul_release", E0);
        nop("ldr_mul_after", E0);

        step("rmul_issue", 4'd0, 4'd0, 4'd0, 4'd3, 1, 0, 0, 1, 0, E0);
        nop("rmul_stall", mk(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        rst_v = 1'b0;
        step("rmul_reset", 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 1, E0);
        rst_v = 1'b1;
        nop("rmul_run", E0);
        nop("rmul_idle", E0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
